// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared states, mode and error codes for the UART command parser.
package uart_cmd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_MODE, S_ADDR, S_DLO, S_DHI, S_CHK, S_ISSUE} state_t;
  localparam logic [1:0] MODE_READ1  = 2'b00;
  localparam logic [1:0] MODE_READ2  = 2'b01;
  localparam logic [1:0] MODE_WRITE1 = 2'b10;
  localparam logic [1:0] MODE_WRITE2 = 2'b11;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_BADMODE = 2'b10;
  localparam logic [1:0] ERR_CHKSUM  = 2'b11;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/uart_cmd_timer.sv
// uart_cmd_timer: inter-byte watchdog; expired pulses when TIMEOUT_CYCLES enabled cycles pass without clear.
module uart_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt;
  // a clear in the expiry cycle wins, so a late byte still keeps the frame alive
  assign expired = enable && !clear && (cnt == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clear || expired || !enable) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles UART command frames into arbiter FIFO write strobes.
// Define UART_CMD_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        buffers_full,
  output logic        wr_addrbuffer,
  output logic        wr_opbuffer,
  output logic        wr_databuffer1,
  output logic        wr_databuffer2,
  output logic [7:0]  addr_pointer,
  output logic [7:0]  mode,
  output logic [15:0] wr_data,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic        rx_overrun,
  output logic        busy
);
`ifdef UART_CMD_CHECKSUM_EN
  localparam state_t TAIL = S_CHK;
  logic [7:0] chk_r;
`else
  localparam state_t TAIL = S_ISSUE;
`endif
  state_t state;
  logic [7:0] m_r, a_r, lo_r, hi_r;
  logic counting, expired;
  assign counting = state inside {S_MODE, S_ADDR, S_DLO, S_DHI, S_CHK};
  uart_cmd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk), .reset(reset), .clear(rx_valid), .enable(counting), .expired(expired)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      {m_r, a_r, lo_r, hi_r} <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      chk_r <= '0;
`endif
      {wr_addrbuffer, wr_opbuffer, wr_databuffer1, wr_databuffer2} <= '0;
      {addr_pointer, mode, wr_data} <= '0;
      {err_valid, err_code, rx_overrun, busy} <= '0;
    end else begin
      {wr_addrbuffer, wr_opbuffer, wr_databuffer1, wr_databuffer2} <= '0;
      err_valid <= 1'b0;
      rx_overrun <= 1'b0;
      // busy trails the state by one cycle so it drops the cycle after the strobes
      busy <= (state != S_IDLE);
      if (expired) begin
        err_valid <= 1'b1;
        err_code <= ERR_TIMEOUT;
        state <= S_IDLE;
      end else case (state)
        S_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state <= S_MODE;
        S_MODE: if (rx_valid) begin
          if (rx_data[7:2] != 6'd0) begin
            err_valid <= 1'b1;
            err_code <= ERR_BADMODE;
            state <= S_IDLE;
          end else begin
            m_r <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
            chk_r <= rx_data;
`endif
            state <= S_ADDR;
          end
        end
        S_ADDR: if (rx_valid) begin
          a_r <= rx_data;
          lo_r <= '0;
          hi_r <= '0;
`ifdef UART_CMD_CHECKSUM_EN
          chk_r <= chk_r ^ rx_data;
`endif
          state <= m_r[1] ? S_DLO : TAIL;
        end
        S_DLO: if (rx_valid) begin
          lo_r <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
          chk_r <= chk_r ^ rx_data;
`endif
          state <= m_r[0] ? S_DHI : TAIL;
        end
        S_DHI: if (rx_valid) begin
          hi_r <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
          chk_r <= chk_r ^ rx_data;
`endif
          state <= TAIL;
        end
`ifdef UART_CMD_CHECKSUM_EN
        S_CHK: if (rx_valid) begin
          if (rx_data != chk_r) begin
            err_valid <= 1'b1;
            err_code <= ERR_CHKSUM;
            state <= S_IDLE;
          end else state <= S_ISSUE;
        end
`endif
        // a byte arriving on the release edge defers the issue so overrun never meets the strobes
        S_ISSUE:
          if (rx_valid) rx_overrun <= 1'b1;
          else if (!buffers_full) begin
            {wr_addrbuffer, wr_opbuffer, wr_databuffer1, wr_databuffer2} <= '1;
            addr_pointer <= a_r;
            mode <= m_r;
            wr_data <= {hi_r, lo_r};
            state <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed and randomized frame checks of uart_cmd_parser against a frame-level model.
module tb_uart_cmd_parser;
  localparam int T = 16;
  logic clk = 0, reset = 0, rx_valid = 0, buffers_full = 0;
  logic [7:0] rx_data = 0;
  logic wr_addrbuffer, wr_opbuffer, wr_databuffer1, wr_databuffer2;
  logic [7:0] addr_pointer, mode;
  logic [15:0] wr_data;
  logic err_valid, rx_overrun, busy;
  logic [1:0] err_code;
  int errors = 0, checks = 0, ovr_n = 0;
  logic [31:0] iss_q[$];
  logic [1:0] err_q[$];
  logic [7:0] fr[$];

  always #5 clk = ~clk;

  uart_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .buffers_full(buffers_full),
    .wr_addrbuffer(wr_addrbuffer), .wr_opbuffer(wr_opbuffer), .wr_databuffer1(wr_databuffer1),
    .wr_databuffer2(wr_databuffer2), .addr_pointer(addr_pointer), .mode(mode), .wr_data(wr_data),
    .err_valid(err_valid), .err_code(err_code), .rx_overrun(rx_overrun), .busy(busy)
  );

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {wr_addrbuffer, wr_opbuffer, wr_databuffer1, wr_databuffer2};
  endfunction

  always @(negedge clk) if (reset) begin
    if (strobes() != 4'h0) begin
      check("strobes_together", 40'(strobes()), 40'hf);
      check("no_err_with_strobe", 40'({err_valid, rx_overrun}), 40'h0);
      iss_q.push_back({addr_pointer, mode, wr_data});
    end
    if (err_valid) err_q.push_back(err_code);
    if (rx_overrun) ovr_n++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic send_fr(input int gmax);
    for (int i = 0; i < fr.size(); i++) begin
      if (i > 0) repeat ($urandom_range(0, gmax)) @(negedge clk);
      send_byte(fr[i]);
    end
  endtask

  task automatic build(input logic [7:0] m, input logic [7:0] a, input logic [7:0] lo, input logic [7:0] hi);
    logic [7:0] x;
    fr = {};
    fr.push_back(8'hA5);
    fr.push_back(m);
    if (m[7:2] != 6'd0) return;
    fr.push_back(a);
    if (m[1]) begin
      fr.push_back(lo);
      if (m[0]) fr.push_back(hi);
    end
`ifdef UART_CMD_CHECKSUM_EN
    x = 8'h00;
    for (int i = 1; i < fr.size(); i++) x ^= fr[i];
    fr.push_back(x);
`endif
  endtask

  function automatic logic [15:0] exp_data(input logic [7:0] m, input logic [7:0] lo, input logic [7:0] hi);
    if (!m[1]) return 16'h0000;
    return m[0] ? {hi, lo} : {8'h00, lo};
  endfunction

  task automatic clear_q();
    iss_q = {};
    err_q = {};
    ovr_n = 0;
  endtask

  task automatic expect_issue(input logic [7:0] a, input logic [7:0] m, input logic [15:0] d);
    check("pre_strobe", 40'(strobes()), 40'h0);
    @(negedge clk);
    check("strobe", 40'(strobes()), 40'hf);
    check("issue_fields", 40'({a, m, d}), 40'({addr_pointer, mode, wr_data}) ^ 40'h0 ^ 40'h0 ^ 40'h0);
    check("busy_in_strobe", 40'(busy), 40'h1);
    @(negedge clk);
    check("strobe_end", 40'(strobes()), 40'h0);
    check("busy_after", 40'(busy), 40'h0);
  endtask

  initial begin
    logic [7:0] m, a, lo, hi, j;
    int kind, n;
    bit trunc, stall, exp_iss, exp_err;
    repeat (2) @(negedge clk);
    check("reset_outputs", {strobes(), addr_pointer, mode, wr_data, err_valid, err_code, rx_overrun, busy}, 40'h0);
    reset = 1;
    @(negedge clk);

    build(8'h03, 8'h02, 8'h34, 8'h12);
    send_fr(0);
    expect_issue(8'h02, 8'h03, 16'h1234);

    build(8'h00, 8'h05, 8'h00, 8'h00);
    send_fr(0);
    expect_issue(8'h05, 8'h00, 16'h0000);

    build(8'h84, 8'h00, 8'h00, 8'h00);
    send_fr(0);
    check("badmode_pulse", 40'({err_valid, err_code}), 40'h6);
    check("badmode_no_strobe", 40'(strobes()), 40'h0);
    @(negedge clk);
    check("badmode_held", 40'({err_valid, err_code}), 40'h2);
    build(8'h02, 8'h07, 8'h99, 8'h00);
    send_fr(0);
    expect_issue(8'h07, 8'h02, 16'h0099);

    fr = {8'hA5, 8'h01};
    send_fr(0);
    repeat (T - 1) @(negedge clk);
    check("timeout_not_early", 40'(err_valid), 40'h0);
    @(negedge clk);
    check("timeout_pulse", 40'({err_valid, err_code}), 40'h5);
    @(negedge clk);
    check("timeout_idle", 40'({busy, err_valid}), 40'h0);

    clear_q();
    send_byte(8'hA5);
    repeat (T - 2) @(negedge clk);
    send_byte(8'h01);
    repeat (T - 1) @(negedge clk);
    send_byte(8'h3C);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h3D);
`endif
    expect_issue(8'h3C, 8'h01, 16'h0000);
    #1;
    check("keepalive_no_err", 40'(err_q.size()), 40'h0);
    @(negedge clk);

    clear_q();
    buffers_full = 1;
    build(8'h03, 8'h11, 8'h22, 8'h33);
    send_fr(0);
    repeat (10) @(negedge clk);
    send_byte(8'h7E);
    repeat (40) @(negedge clk);
    #1;
    check("stall_no_strobe", 40'(iss_q.size()), 40'h0);
    check("stall_overrun", 40'(ovr_n), 40'h1);
    @(negedge clk);
    buffers_full = 0;
    @(negedge clk);
    check("release_strobe", 40'(strobes()), 40'hf);
    check("release_fields", 40'({addr_pointer, mode, wr_data}), 40'h11033322);

`ifdef UART_CMD_CHECKSUM_EN
    repeat (2) @(negedge clk);
    fr = {8'hA5, 8'h02, 8'h10, 8'h33, 8'hFF};
    send_fr(0);
    check("chk_err", 40'({err_valid, err_code}), 40'h7);
    @(negedge clk);
    check("chk_no_strobe", 40'(strobes()), 40'h0);
`endif

    repeat (2) @(negedge clk);
    fr = {8'hA5, 8'h03, 8'h11};
    send_fr(0);
    reset = 0;
    #1;
    check("midframe_reset", {strobes(), addr_pointer, mode, wr_data, err_valid, err_code, rx_overrun, busy}, 40'h0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    build(8'h02, 8'h44, 8'h55, 8'h00);
    send_fr(0);
    expect_issue(8'h44, 8'h02, 16'h0055);

    for (int f = 0; f < 60; f++) begin
      clear_q();
      if ($urandom_range(0, 3) == 0) begin
        j = 8'($urandom_range(0, 255));
        if (j == 8'hA5) j = 8'h5A;
        send_byte(j);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      kind = $urandom_range(0, 9);
      m = (kind == 0) ? {6'($urandom_range(1, 63)), 2'($urandom_range(0, 3))} : 8'($urandom_range(0, 3));
      a = 8'($urandom);
      lo = 8'($urandom);
      hi = 8'($urandom);
      build(m, a, lo, hi);
      trunc = (kind == 1);
      if (trunc) begin
        n = $urandom_range(1, fr.size() - 1);
        while (fr.size() > n) void'(fr.pop_back());
      end
      stall = !trunc && kind != 0 && $urandom_range(0, 2) == 0;
      if (stall) buffers_full = 1;
      send_fr(T - 2);
      if (trunc) repeat (T + 3) @(negedge clk);
      else if (stall) begin
        repeat (2) @(negedge clk);
        send_byte(8'h7E);
        repeat ($urandom_range(1, 10)) @(negedge clk);
        buffers_full = 0;
        repeat (4) @(negedge clk);
      end else repeat (4) @(negedge clk);
      #1;
      exp_iss = kind != 0 && !trunc;
      exp_err = kind == 0 || trunc;
      check("rnd_issue_count", 40'(iss_q.size()), 40'(exp_iss));
      if (exp_iss && iss_q.size() == 1) check("rnd_issue_data", 40'(iss_q[0]), 40'({a, m, exp_data(m, lo, hi)}));
      check("rnd_err_count", 40'(err_q.size()), 40'(exp_err));
      if (exp_err && err_q.size() == 1) check("rnd_err_code", 40'(err_q[0]), (kind == 0) ? 40'h2 : 40'h1);
      check("rnd_overrun", 40'(ovr_n), 40'(stall));
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
